i2c_eeprom_rd_ctrl: RTL and testbench

//  Sequencer for a byte-level I2C master: reads len_i bytes from a 16-bit-addressed EEPROM

---
 rtl/i2c_eeprom_ctrl_pkg.sv | 36 +++
 rtl/i2c_eeprom_rd_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_i2c_eeprom_rd_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_eeprom_ctrl_pkg.sv
// Shared types for the I2C EEPROM random-read sequencer: FSM states, error codes,
// R/W bit values and the registered byte-controller command bundle.
package i2c_eeprom_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEV_W,
    ADDR_HI,
    ADDR_LO,
    DEV_R,
    READ,
    OUT,
    ERR_STOP
  } state_e;

  typedef enum logic [2:0] {
    ERR_OK        = 3'd0,
    ERR_NACK_DEV  = 3'd1,
    ERR_NACK_ADDR = 3'd2,
    ERR_ARB_LOST  = 3'd3,
    ERR_TIMEOUT   = 3'd4
  } err_code_e;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       read;
    logic       write;
    logic       ack;
    logic [7:0] data;
  } cmd_t;

endpackage

// File: rtl/i2c_eeprom_rd_ctrl.sv
// Random-read sequencer for a byte-level I2C master: S, dev+W, addr_hi, addr_lo,
// Sr, dev+R, N reads (last NACK+STOP), streaming received bytes on valid/ready.
module i2c_eeprom_rd_ctrl
  import i2c_eeprom_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [6:0]       dev_addr_i,
  input  logic [15:0]      mem_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [2:0]       err_code_o,
  output logic             cmd_start_o,
  output logic             cmd_stop_o,
  output logic             cmd_read_o,
  output logic             cmd_write_o,
  output logic             cmd_ack_o,
  output logic [7:0]       cmd_data_o,
  input  logic             cmd_ack_i,
  input  logic             rx_ack_i,
  input  logic [7:0]       rx_data_i,
  input  logic             al_i,
  output logic [7:0]       data_o,
  output logic             data_valid_o,
  input  logic             data_ready_i
);

  localparam int unsigned TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic TMO_EN = (TIMEOUT_CYCLES != 0);

  state_e           state_q, state_d;
  err_code_e        err_code_q, err_code_d;
  cmd_t             cmd_q, cmd_d;
  logic [6:0]       dev_q, dev_d;
  logic [15:0]      addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [7:0]       data_q, data_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             cmd_busy;
  logic             last_byte;

  assign cmd_busy  = cmd_q.start | cmd_q.stop | cmd_q.read | cmd_q.write;
  assign last_byte = (rem_q == LEN_W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      err_code_q <= ERR_OK;
      cmd_q      <= '0;
      dev_q      <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      data_q     <= '0;
      tmo_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
      cmd_q      <= cmd_d;
      dev_q      <= dev_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      data_q     <= data_d;
      tmo_q      <= tmo_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    cmd_d      = cmd_q;
    dev_d      = dev_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    data_d     = data_q;
    tmo_d      = tmo_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (state_q == IDLE) begin
      if (start_i) begin
        dev_d      = dev_addr_i;
        addr_d     = mem_addr_i;
        rem_d      = len_i;
        err_code_d = ERR_OK;
        if (len_i == '0) done_d = 1'b1;
        else             state_d = DEV_W;
      end
    end else if (al_i) begin
      // Arbitration loss wins over a simultaneous ack; the bus is no longer ours, so no STOP.
      cmd_d      = '0;
      err_code_d = ERR_ARB_LOST;
      err_d      = 1'b1;
      state_d    = IDLE;
    end else if (cmd_busy) begin
      if (cmd_ack_i) begin
        cmd_d = '0;
        unique case (state_q)
          DEV_W: begin
            state_d = rx_ack_i ? ERR_STOP : ADDR_HI;
            if (rx_ack_i) err_code_d = ERR_NACK_DEV;
          end
          ADDR_HI: begin
            state_d = rx_ack_i ? ERR_STOP : ADDR_LO;
            if (rx_ack_i) err_code_d = ERR_NACK_ADDR;
          end
          ADDR_LO: begin
            state_d = rx_ack_i ? ERR_STOP : DEV_R;
            if (rx_ack_i) err_code_d = ERR_NACK_ADDR;
          end
          DEV_R: begin
            state_d = rx_ack_i ? ERR_STOP : READ;
            if (rx_ack_i) err_code_d = ERR_NACK_DEV;
          end
          READ: begin
            data_d  = rx_data_i;
            state_d = OUT;
          end
          ERR_STOP: begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end else if (TMO_EN && tmo_q == TMO_MAX) begin
        cmd_d      = '0;
        err_code_d = ERR_TIMEOUT;
        err_d      = 1'b1;
        state_d    = IDLE;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end else begin
      // No command outstanding: this is the idle gap cycle, issue the state's command.
      tmo_d = '0;
      unique case (state_q)
        DEV_W: begin
          cmd_d.start = 1'b1;
          cmd_d.write = 1'b1;
          cmd_d.data  = {dev_q, RW_WRITE};
        end
        ADDR_HI: begin
          cmd_d.write = 1'b1;
          cmd_d.data  = addr_q[15:8];
        end
        ADDR_LO: begin
          cmd_d.write = 1'b1;
          cmd_d.data  = addr_q[7:0];
        end
        DEV_R: begin
          cmd_d.start = 1'b1;
          cmd_d.write = 1'b1;
          cmd_d.data  = {dev_q, RW_READ};
        end
        READ: begin
          cmd_d.read = 1'b1;
          cmd_d.ack  = last_byte;
          cmd_d.stop = last_byte;
        end
        OUT: begin
          if (data_ready_i) begin
            rem_d = rem_q - LEN_W'(1);
            if (last_byte) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = READ;
            end
          end
        end
        ERR_STOP: cmd_d.stop = 1'b1;
        default:  state_d = IDLE;
      endcase
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign data_valid_o = (state_q == OUT);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;
  assign cmd_start_o  = cmd_q.start;
  assign cmd_stop_o   = cmd_q.stop;
  assign cmd_read_o   = cmd_q.read;
  assign cmd_write_o  = cmd_q.write;
  assign cmd_ack_o    = cmd_q.ack;
  assign cmd_data_o   = cmd_q.data;
  assign data_o       = data_q;

endmodule

// File: tb/tb_i2c_eeprom_rd_ctrl.sv
// Directed bench for i2c_eeprom_rd_ctrl with a behavioural byte controller and EEPROM slave at 7'h2A.
module tb_i2c_eeprom_rd_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [6:0]  dev_addr_i = '0;
  logic [15:0] mem_addr_i = '0;
  logic [15:0] len_i = '0;
  logic        busy_o, done_o, err_o;
  logic [2:0]  err_code_o;
  logic        cmd_start_o, cmd_stop_o, cmd_read_o, cmd_write_o, cmd_ack_o;
  logic [7:0]  cmd_data_o;
  logic        cmd_ack_i = 1'b0;
  logic        rx_ack_i = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        al_i = 1'b0;
  logic [7:0]  data_o;
  logic        data_valid_o;
  logic        data_ready_i = 1'b1;

  i2c_eeprom_rd_ctrl #(.LEN_W(16), .TIMEOUT_CYCLES(100)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .dev_addr_i(dev_addr_i),
    .mem_addr_i(mem_addr_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .err_code_o(err_code_o), .cmd_start_o(cmd_start_o),
    .cmd_stop_o(cmd_stop_o), .cmd_read_o(cmd_read_o), .cmd_write_o(cmd_write_o),
    .cmd_ack_o(cmd_ack_o), .cmd_data_o(cmd_data_o), .cmd_ack_i(cmd_ack_i),
    .rx_ack_i(rx_ack_i), .rx_data_i(rx_data_i), .al_i(al_i), .data_o(data_o),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Byte controller + EEPROM slave model
  logic [7:0]  mem [256];
  logic        bc_en = 1'b1;
  int          bc_lat = 2;
  int          bc_wait = 0;
  logic        bc_acked = 1'b0;
  logic        s_sel = 1'b0;
  int          s_idx = 0;
  logic [15:0] s_ptr = '0;
  int          rd_cnt = 0, nack_cnt = 0, stop_cnt = 0;
  logic        last_rd_ack = 1'b0, last_rd_stop = 1'b0;

  task automatic slave_op();
    rx_ack_i = 1'b0;
    if (cmd_write_o) begin
      if (cmd_start_o) begin
        s_sel    = (cmd_data_o[7:1] == 7'h2A);
        s_idx    = 0;
        rx_ack_i = !s_sel;
      end else if (!s_sel) begin
        rx_ack_i = 1'b1;
      end else begin
        if (s_idx == 0) s_ptr[15:8] = cmd_data_o;
        else            s_ptr[7:0]  = cmd_data_o;
        s_idx++;
      end
    end
    if (cmd_read_o) begin
      rx_data_i    = mem[s_ptr[7:0]];
      s_ptr        = s_ptr + 16'd1;
      rd_cnt++;
      last_rd_ack  = cmd_ack_o;
      last_rd_stop = cmd_stop_o;
      if (cmd_ack_o) nack_cnt++;
    end
    if (cmd_stop_o) begin
      stop_cnt++;
      s_sel = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk_i); #1;
    cmd_ack_i = 1'b0;
    if (!(cmd_start_o | cmd_stop_o | cmd_read_o | cmd_write_o)) begin
      bc_wait  = 0;
      bc_acked = 1'b0;
    end else if (bc_en && !bc_acked) begin
      if (bc_wait < bc_lat) bc_wait++;
      else begin
        bc_acked  = 1'b1;
        cmd_ack_i = 1'b1;
        slave_op();
      end
    end
  end

  // Output monitor, sampled on the falling edge
  int         done_cnt = 0, err_cnt = 0, valid_seen = 0, cmd_seen = 0, stop_hi = 0, rd_while_valid = 0;
  logic [7:0] rx_q [$];

  initial forever begin
    @(negedge clk_i);
    if (done_o) done_cnt++;
    if (err_o) err_cnt++;
    if (data_valid_o) valid_seen++;
    if (cmd_start_o | cmd_stop_o | cmd_read_o | cmd_write_o) cmd_seen++;
    if (cmd_stop_o) stop_hi++;
    if (data_valid_o && cmd_read_o) rd_while_valid++;
    if (data_valid_o && data_ready_i) rx_q.push_back(data_o);
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic clear_mon();
    done_cnt = 0; err_cnt = 0; valid_seen = 0; cmd_seen = 0; stop_hi = 0; rd_while_valid = 0;
    rd_cnt = 0; nack_cnt = 0; stop_cnt = 0;
    rx_q.delete();
  endtask

  task automatic do_start(input logic [6:0] dev, input logic [15:0] addr, input logic [15:0] len);
    start_i = 1'b1; dev_addr_i = dev; mem_addr_i = addr; len_i = len;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int lim);
    int n = 0;
    while (!(done_o || err_o) && n < lim) begin
      tick();
      n++;
    end
    check(tag, 32'(done_o | err_o), 32'd1);
    repeat (3) tick();
  endtask

  function automatic logic [27:0] all_outs();
    return {busy_o, done_o, err_o, err_code_o, cmd_start_o, cmd_stop_o, cmd_read_o,
            cmd_write_o, cmd_ack_o, cmd_data_o, data_o, data_valid_o};
  endfunction

  logic [7:0] exp_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    mem[16] = 8'h11; mem[17] = 8'h22; mem[18] = 8'h33; mem[19] = 8'h44;

    repeat (3) tick();
    check("reset_outputs", 32'(all_outs()), 32'd0);
    rst_i = 1'b0;
    tick();

    // 1: plain 4-byte read, with an extra start while busy that must be ignored
    clear_mon();
    do_start(7'h2A, 16'h0010, 16'd4);
    repeat (4) tick();
    check("t1_busy", 32'(busy_o), 32'd1);
    do_start(7'h2B, 16'h0000, 16'd0);
    wait_end("t1_end_seen", 2000);
    check("t1_nbytes", rx_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < rx_q.size()) check($sformatf("t1_byte%0d", i), 32'(rx_q[i]), 32'(exp_bytes[i]));
    check("t1_done_cnt", done_cnt, 32'd1);
    check("t1_err_cnt", err_cnt, 32'd0);
    check("t1_err_code", 32'(err_code_o), 32'd0);
    check("t1_reads", rd_cnt, 32'd4);
    check("t1_last_nack", 32'(last_rd_ack), 32'd1);
    check("t1_last_stop", 32'(last_rd_stop), 32'd1);
    check("t1_nack_cnt", nack_cnt, 32'd1);
    check("t1_stop_cnt", stop_cnt, 32'd1);

    // 2: wrong device address
    clear_mon();
    do_start(7'h2B, 16'h0010, 16'd2);
    wait_end("t2_end_seen", 2000);
    check("t2_err_code", 32'(err_code_o), 32'd1);
    check("t2_err_cnt", err_cnt, 32'd1);
    check("t2_done_cnt", done_cnt, 32'd0);
    check("t2_stop_cnt", stop_cnt, 32'd1);
    check("t2_valid_seen", valid_seen, 32'd0);

    // 3: consumer stalls 20 cycles on the second byte
    clear_mon();
    do_start(7'h2A, 16'h0010, 16'd4);
    begin
      int n = 0;
      int bad = 0;
      logic [7:0] held;
      while (!(data_valid_o && rx_q.size() == 1) && n < 500) begin
        tick();
        n++;
      end
      data_ready_i = 1'b0;
      held = data_o;
      check("t3_byte2_valid", 32'(data_valid_o), 32'd1);
      check("t3_byte2", 32'(data_o), 32'h22);
      repeat (20) begin
        tick();
        if (data_o !== held || data_valid_o !== 1'b1) bad++;
      end
      data_ready_i = 1'b1;
      check("t3_stable", bad, 32'd0);
    end
    wait_end("t3_end_seen", 2000);
    check("t3_read_in_out", rd_while_valid, 32'd0);
    check("t3_nbytes", rx_q.size(), 32'd4);
    for (int i = 2; i < 4; i++)
      if (i < rx_q.size()) check($sformatf("t3_byte%0d", i), 32'(rx_q[i]), 32'(exp_bytes[i]));
    check("t3_done_cnt", done_cnt, 32'd1);

    // 4: zero-length request
    clear_mon();
    do_start(7'h2A, 16'h0010, 16'd0);
    check("t4_done_pulse", 32'(done_o), 32'd1);
    tick();
    check("t4_done_low", 32'(done_o), 32'd0);
    check("t4_idle", 32'(busy_o), 32'd0);
    repeat (5) tick();
    check("t4_no_cmd", cmd_seen, 32'd0);
    check("t4_done_cnt", done_cnt, 32'd1);

    // 5: arbitration lost while the low address byte is on the bus
    clear_mon();
    bc_lat = 4;
    do_start(7'h2A, 16'h0010, 16'd4);
    begin
      int n = 0;
      while (!(cmd_write_o && !cmd_start_o && cmd_data_o == 8'h10) && n < 300) begin
        tick();
        n++;
      end
    end
    al_i = 1'b1;
    tick();
    al_i = 1'b0;
    check("t5_idle", 32'(busy_o), 32'd0);
    check("t5_err_pulse", 32'(err_o), 32'd1);
    check("t5_err_code", 32'(err_code_o), 32'd3);
    check("t5_cmds_dropped", 32'({cmd_start_o, cmd_stop_o, cmd_read_o, cmd_write_o}), 32'd0);
    repeat (5) tick();
    check("t5_no_stop", stop_hi, 32'd0);
    check("t5_err_cnt", err_cnt, 32'd1);

    // 6: byte controller never acknowledges
    clear_mon();
    bc_en = 1'b0;
    do_start(7'h2A, 16'h0010, 16'd4);
    begin
      int n = 0;
      while (!cmd_start_o && n < 10) begin
        tick();
        n++;
      end
      n = 0;
      while (!err_o && n < 300) begin
        tick();
        n++;
      end
      check("t6_tmo_cycles", n, 32'd100);
    end
    check("t6_err_code", 32'(err_code_o), 32'd4);
    check("t6_cmds_dropped", 32'({cmd_start_o, cmd_stop_o, cmd_read_o, cmd_write_o}), 32'd0);
    check("t6_idle", 32'(busy_o), 32'd0);

    // 6b: reset in the middle of a read
    bc_en = 1'b1;
    bc_lat = 6;
    repeat (3) tick();
    clear_mon();
    do_start(7'h2A, 16'h0010, 16'd4);
    begin
      int n = 0;
      while (!cmd_read_o && n < 300) begin
        tick();
        n++;
      end
      check("t6b_in_read", 32'(cmd_read_o), 32'd1);
    end
    rst_i = 1'b1;
    tick();
    check("t6b_reset_outputs", 32'(all_outs()), 32'd0);
    rst_i = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
